// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// Bytes come in over a valid/ready handshake and are shifted out LSB first.
// An internal baud counter sets the bit timing, so no divided clock is needed.
module uart_transmitter #(
    parameter  int CLOCKS_PER_BIT = 625,
    parameter  int FIFO_DEPTH     = 4,
    localparam int PTR_W          = $clog2(FIFO_DEPTH),
    localparam int LVL_W          = PTR_W + 1
) (
    input  logic             clock_72mhz,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    // The counter is 11 bits wide, which covers the largest legal bit period (2047).
    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_baud_cnt;
    logic             r_uart_tx;
    logic             r_busy;

    logic w_push;
    logic w_pop;
    logic w_bit_end;
    logic w_nonempty;

    // tx_ready is combinational so a producer sees space on the same cycle it frees up.
    assign tx_ready   = !reset && (r_level != LVL_W'(FIFO_DEPTH));
    assign w_push     = tx_valid && tx_ready;
    assign w_nonempty = (r_level != '0);
    assign w_bit_end  = (r_baud_cnt == CNT_W'(CLOCKS_PER_BIT - 1));
    // The head byte leaves the FIFO whenever the FSM heads into a start bit.
    assign w_pop      = w_nonempty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    assign uart_tx    = r_uart_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;

    // Write the accepted byte into FIFO storage.
    // NOTE: storage has no reset; only pointers and level need a known value, and
    // leaving the array out of reset lets it map onto plain registers or LUT RAM.
    always_ff @(posedge clock_72mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // Advance FIFO pointers and keep the level in step with push and pop.
    // NOTE: every register update uses <= so all state reads see pre-edge values.
    always_ff @(posedge clock_72mhz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, one stop bit.
    always_ff @(posedge clock_72mhz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_uart_tx  <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_uart_tx  <= 1'b1;
                    if (w_nonempty) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_state   <= S_START;
                        r_uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
                        r_uart_tx  <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= S_STOP;
                            r_uart_tx <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_uart_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_nonempty) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            r_shift   <= r_mem[r_rd_ptr];
                            r_state   <= S_START;
                            r_uart_tx <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_tx <= 1'b1;
                end
            endcase

            // busy rises with any new work and falls only when the last stop bit
            // ends with nothing queued and nothing arriving.
            if (w_push || w_pop) begin
                r_busy <= 1'b1;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
